// File: rtl/uart_wr_fifo.sv
// UART-to-SDRAM write-path rate adapter: buffers received bytes locally and
// forwards them to the SDRAM write FIFO only as whole bursts of burst_len bytes.
module uart_wr_fifo #(
    parameter int          DEPTH            = 1024,
    parameter logic [9:0]  SDRAM_FIFO_DEPTH = 10'd1023,
    parameter logic [17:0] TIMEOUT_MAX      = 18'd156239,
    parameter logic [7:0]  PAD_BYTE         = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    input  logic [9:0]  burst_len,
    input  logic [9:0]  sdram_wr_fifo_cnt,
    output logic        sdram_fifo_wr_en,
    output logic [7:0]  sdram_fifo_wr_data,
    output logic [10:0] data_num,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [17:0] idle_cnt;
    logic [9:0]  take;
    logic [9:0]  cnt;

    logic fifo_full;
    logic fifo_wr;
    logic fifo_rd;
    logic space_ok;
    logic full_go;
    logic flush_go;

    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_wr   = rx_flag && !fifo_full;
    assign fifo_rd   = (state == BURST) && (cnt < take);

    // Sum in 11 bits so a large fill level plus burst length cannot wrap.
    assign space_ok = ({1'b0, sdram_wr_fifo_cnt} + {1'b0, burst_len}) <= {1'b0, SDRAM_FIFO_DEPTH};
    assign full_go  = (burst_len != 10'd0) && (data_num >= {1'b0, burst_len});
    assign flush_go = (idle_cnt == TIMEOUT_MAX) && (data_num != 11'd0) &&
                      (data_num < {1'b0, burst_len});

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_num <= 11'd0;
            overflow <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   data_num <= data_num + 11'd1;
                2'b01:   data_num <= data_num - 11'd1;
                default: data_num <= data_num;
            endcase
            if (rx_flag && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 18'd0;
        end else if (rx_flag || (state != IDLE) || (data_num == 11'd0)) begin
            idle_cnt <= 18'd0;
        end else if (idle_cnt != TIMEOUT_MAX) begin
            idle_cnt <= idle_cnt + 18'd1;
        end
    end

    // cnt counts bytes emitted in the current burst; the extra BURST cycle at
    // cnt==take either starts padding or closes the strobe run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            take               <= 10'd0;
            cnt                <= 10'd0;
            busy               <= 1'b0;
            sdram_fifo_wr_en   <= 1'b0;
            sdram_fifo_wr_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    sdram_fifo_wr_en <= 1'b0;
                    cnt              <= 10'd0;
                    if (space_ok && (full_go || flush_go)) begin
                        state <= BURST;
                        busy  <= 1'b1;
                        take  <= full_go ? burst_len : data_num[9:0];
                    end
                end
                BURST: begin
                    if (cnt < take) begin
                        sdram_fifo_wr_en   <= 1'b1;
                        sdram_fifo_wr_data <= mem[rd_ptr[AW-1:0]];
                        cnt                <= cnt + 10'd1;
                    end else if (take == burst_len) begin
                        state            <= IDLE;
                        busy             <= 1'b0;
                        sdram_fifo_wr_en <= 1'b0;
                    end else begin
                        state              <= PAD;
                        sdram_fifo_wr_en   <= 1'b1;
                        sdram_fifo_wr_data <= PAD_BYTE;
                        cnt                <= cnt + 10'd1;
                    end
                end
                PAD: begin
                    if (cnt < burst_len) begin
                        sdram_fifo_wr_en   <= 1'b1;
                        sdram_fifo_wr_data <= PAD_BYTE;
                        cnt                <= cnt + 10'd1;
                    end else begin
                        state            <= IDLE;
                        busy             <= 1'b0;
                        sdram_fifo_wr_en <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    sdram_fifo_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wr_fifo.sv
// Randomized scoreboard bench for uart_wr_fifo: a queue-level model predicts the
// byte stream and burst lengths; a negedge monitor pops and compares.
module tb_uart_wr_fifo;

    localparam int TMO = 300;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic [9:0]  burst_len;
    logic [9:0]  sdram_wr_fifo_cnt;
    logic        sdram_fifo_wr_en;
    logic [7:0]  sdram_fifo_wr_data;
    logic [10:0] data_num;
    logic        busy;
    logic        overflow;

    uart_wr_fifo #(
        .DEPTH            (1024),
        .SDRAM_FIFO_DEPTH (10'd1023),
        .TIMEOUT_MAX      (18'(TMO)),
        .PAD_BYTE         (8'h00)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_data            (rx_data),
        .rx_flag            (rx_flag),
        .burst_len          (burst_len),
        .sdram_wr_fifo_cnt  (sdram_wr_fifo_cnt),
        .sdram_fifo_wr_en   (sdram_fifo_wr_en),
        .sdram_fifo_wr_data (sdram_fifo_wr_data),
        .data_num           (data_num),
        .busy               (busy),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    int         exp_run_q[$];
    int         bl       = 8;
    int         cnt_val  = 0;
    logic       exp_ovf  = 1'b0;
    int         n_acc    = 0;
    int         run_len  = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    // Whole bursts leave the local buffer as soon as one is buffered and space exists.
    function automatic void model_drain();
        while (bl != 0 && cnt_val + bl <= 1023 && model_q.size() >= bl) begin
            for (int i = 0; i < bl; i++) exp_q.push_back(model_q.pop_front());
            exp_run_q.push_back(bl);
        end
    endfunction

    // A timed-out partial burst is emitted in full and completed with zero bytes.
    function automatic void model_flush();
        int n;
        if (bl != 0 && cnt_val + bl <= 1023 && model_q.size() > 0 && model_q.size() < bl) begin
            n = model_q.size();
            for (int i = 0; i < n; i++) exp_q.push_back(model_q.pop_front());
            for (int i = n; i < bl; i++) exp_q.push_back(8'h00);
            exp_run_q.push_back(bl);
        end
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < 1024) model_q.push_back(b);
        else exp_ovf = 1'b1;
        model_drain();
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_flag = 1'b1;
        model_push(b);
        @(posedge clk);
        n_acc++;
        #1;
        rx_flag = 1'b0;
    endtask

    task automatic set_len(input int l);
        @(posedge clk); #1;
        burst_len = 10'(l);
        bl = l;
        model_drain();
    endtask

    task automatic set_cnt(input int c);
        @(posedge clk); #1;
        sdram_wr_fifo_cnt = 10'(c);
        cnt_val = c;
        model_drain();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain_done"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
        repeat (2) @(negedge clk);
        check({name, "_runs_done"}, 32'(exp_run_q.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the next expected byte; every strobe run
    // must match the next expected burst length.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (sdram_fifo_wr_en) begin
            check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("wr_data", 32'(sdram_fifo_wr_data), 32'(exp_q.pop_front()));
            run_len++;
        end else if (run_len > 0) begin
            check("run_expected", 32'(exp_run_q.size() > 0), 32'd1);
            if (exp_run_q.size() > 0) check("run_len", 32'(run_len), 32'(exp_run_q.pop_front()));
            run_len = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nb;
        int t;
        int base;
        rst_n = 1'b0;
        rx_flag = 1'b0;
        rx_data = 8'h00;
        burst_len = 10'd8;
        sdram_wr_fifo_cnt = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(sdram_fifo_wr_en), 32'd0);
        check("rst_wr_data", 32'(sdram_fifo_wr_data), 32'd0);
        check("rst_data_num", 32'(data_num), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // 1: eight bytes, one full burst, latency and busy width
        set_len(8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        fork
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!sdram_fifo_wr_en && k < 20);
                check("t1_first_strobe_latency", 32'(k), 32'd3);
            end
            begin
                nb = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (busy) nb++;
                end
                check("t1_busy_cycles", 32'(nb), 32'd9);
            end
        join
        wait_drain("t1");
        check("t1_data_num", 32'(data_num), 32'd0);

        // 2: partial burst flushed after idle timeout and padded
        set_len(4);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        model_flush();
        wait_drain("t2");
        idle_cycles(TMO + 50);
        check("t2_data_num", 32'(data_num), 32'd0);

        // 3: no burst without SDRAM space; flush deferred until space returns
        set_cnt(1010);
        set_len(16);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)));
        idle_cycles(TMO + 50);
        check("t3_held_data_num", 32'(data_num), 32'd20);
        set_cnt(1000);
        wait_drain("t3a");
        check("t3_after_burst_data_num", 32'(data_num), 32'd4);
        set_cnt(1010);
        idle_cycles(TMO + 50);
        check("t3_no_flush_data_num", 32'(data_num), 32'd4);
        set_cnt(1000);
        model_flush();
        wait_drain("t3b");
        check("t3_final_data_num", 32'(data_num), 32'd0);

        // burst_len of zero never starts a burst
        set_cnt(0);
        set_len(0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        idle_cycles(TMO + 50);
        check("len0_data_num", 32'(data_num), 32'd5);
        set_len(5);
        wait_drain("len0");

        // 4: overflow with SDRAM side full, then drain of the kept 1024 bytes
        set_len(8);
        set_cnt(1023);
        check("t4_overflow_before", 32'(overflow), 32'd0);
        for (int i = 0; i < 1026; i++) send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        check("t4_data_num_full", 32'(data_num), 32'(model_q.size()));
        check("t4_overflow_set", 32'(overflow), 32'(exp_ovf));
        set_cnt(0);
        wait_drain("t4");
        check("t4_data_num_empty", 32'(data_num), 32'd0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // 5: receive every third cycle during a 32-byte burst
        set_len(32);
        base = n_acc;
        for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)));
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    send_byte(8'($urandom_range(0, 255)));
                    idle_cycles(1);
                end
            end
            begin
                t = 0;
                while (!busy && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                while (busy && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check("t5_first_burst_ended", 32'(t < 100), 32'd1);
                check("t5_data_num_mid", 32'(data_num), 32'(n_acc - base - 32));
            end
        join
        wait_drain("t5");
        check("t5_data_num", 32'(data_num), 32'd0);

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            set_len($urandom_range(1, 40));
            nb = $urandom_range(0, 90);
            for (int i = 0; i < nb; i++) begin
                send_byte(8'($urandom_range(0, 255)));
                idle_cycles($urandom_range(0, 4));
            end
            model_flush();
            wait_drain("rand");
            check("rand_data_num", 32'(data_num), 32'(model_q.size()));
        end
        check("overflow_held", 32'(overflow), 32'd1);

        // 6: asynchronous reset at burst cycle 5, then a normal burst
        set_len(8);
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
        k = 0;
        t = 0;
        while (k < 5 && t < 50) begin
            @(negedge clk);
            if (sdram_fifo_wr_en) k++;
            t++;
        end
        check("t6_reached_cycle5", 32'(k), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_wr_en_async", 32'(sdram_fifo_wr_en), 32'd0);
        check("t6_data_num_async", 32'(data_num), 32'd0);
        check("t6_overflow_async", 32'(overflow), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        model_q.delete();
        exp_q.delete();
        exp_run_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i));
        wait_drain("t6");
        check("t6_data_num", 32'(data_num), 32'd0);
        check("t6_overflow", 32'(overflow), 32'(exp_ovf));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_wr_fifo.md
Name: uart_wr_fifo

Overview:
Serial-to-SDRAM write-path rate adapter. Collects bytes arriving slowly from the UART receiver (rx_data/rx_flag) in a local byte FIFO. Once a full burst is buffered and the SDRAM interface write FIFO has room, it pushes exactly burst_len bytes back-to-back into that FIFO. After an idle timeout, a partial burst is flushed and padded to burst_len, so the SDRAM side only ever sees whole bursts.

Parameters:
DEPTH, 1024, local FIFO depth in bytes (power of two; pointers are log2(DEPTH)+1 bits wide)
SDRAM_FIFO_DEPTH, 10'd1023, usable capacity of the SDRAM interface write FIFO
TIMEOUT_MAX, 18'd156239, idle cycles before a partial-burst flush (3 UART frames at 5208 clk/bit)
PAD_BYTE, 8'h00, filler byte used to complete a flushed burst

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from UART receiver, valid when rx_flag=1
rx_flag  input  1  one-cycle strobe: rx_data valid
burst_len  input  10  SDRAM burst length in bytes, legal range 1..1023, held stable while busy=1
sdram_wr_fifo_cnt  input  10  current fill level of the SDRAM interface write FIFO
sdram_fifo_wr_en  output  1  write strobe to the SDRAM write FIFO
sdram_fifo_wr_data  output  8  byte to the SDRAM write FIFO, aligned with sdram_fifo_wr_en
data_num  output  11  local FIFO occupancy, 0..DEPTH
busy  output  1  high while in BURST or PAD
overflow  output  1  sticky: a received byte was dropped because the local FIFO was full

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; pointers, data_num, counters = 0; sdram_fifo_wr_en=0; sdram_fifo_wr_data=0; busy=0; overflow=0. Asserting reset mid-burst aborts the burst immediately; a partial SDRAM-side burst is acceptable on reset only.
- Local FIFO write: on rx_flag=1 with data_num<DEPTH, store rx_data. With data_num==DEPTH, drop the byte and set overflow=1, held until reset.
- Local FIFO read: internal, driven only by the FSM.
- data_num update: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Space check: space_ok = (sdram_wr_fifo_cnt + burst_len <= SDRAM_FIFO_DEPTH), computed at 11 bits to avoid wrap.
- Idle counter: clears on rx_flag, on any state other than IDLE, and when data_num==0. Otherwise increments in IDLE, saturating at TIMEOUT_MAX.
- FSM states: IDLE, BURST, PAD.
  - IDLE -> BURST: when space_ok and either data_num>=burst_len (full burst) or idle counter==TIMEOUT_MAX with 0<data_num<burst_len (flush). Latch take = min(data_num, burst_len). Burst counter = 0.
  - BURST: one local read per cycle. Data enters the output register, giving 1-cycle latency. sdram_fifo_wr_en=1 in the cycle each byte appears. After take reads: if take==burst_len go to IDLE, else go to PAD.
  - PAD: drive sdram_fifo_wr_data=PAD_BYTE with sdram_fifo_wr_en=1 for burst_len-take cycles, then go to IDLE.
- Output timing: sdram_fifo_wr_en is high for exactly burst_len consecutive cycles per burst, with no gaps across the BURST->PAD boundary. The first strobe occurs 2 cycles after the start condition is sampled.
- Byte order and integrity: bytes reach the SDRAM side in exact arrival order, never duplicated or reordered.
- Receive during burst: rx_flag during BURST/PAD is accepted normally; simultaneous write and read is legal.
- Burst spacing: a new burst may start only from IDLE. The minimum gap between bursts is 1 cycle with sdram_fifo_wr_en=0.
- Pointer wrap: pointers wrap modulo DEPTH; the extra MSB distinguishes full from empty.
- burst_len=0: never starts a burst; data accumulates until full.

Test Plan:
1. burst_len=8, sdram_wr_fifo_cnt=0, 8 rx_flag bytes 01..08 -> 8 consecutive sdram_fifo_wr_en pulses carrying 01..08 in order; data_num returns to 0; busy high for 9 cycles.
2. burst_len=4, 3 bytes AA,BB,CC, then idle TIMEOUT_MAX cycles -> 4 strobes AA,BB,CC,00; no further bursts.
3. burst_len=16, sdram_wr_fifo_cnt=1010, 20 bytes buffered -> no strobe; lower cnt to 1000 -> one 16-byte burst; data_num=4 afterwards; no timeout flush while cnt stays high, flush occurs once space returns.
4. DEPTH+2 bytes with sdram_wr_fifo_cnt held at 1023 -> data_num saturates at 1024, overflow=1, stays 1; first 1024 bytes emitted intact once space allows.
5. rx_flag pulses every 3 cycles during an active 32-byte burst -> no byte lost; data_num correct after simultaneous write/read cycles; second burst follows in order.
6. rst_n low at burst cycle 5 -> sdram_fifo_wr_en=0, data_num=0, overflow=0 immediately (asynchronous); normal 8-byte burst works after release.
